cp0_exc_unit: RTL and testbench

//  CP0 register file and precise-exception controller for the 5-stage pipeline, sitting beside writeback.

---
 rtl/cp0_exc_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// CP0 register file and precise-exception controller, placed beside writeback.
// Holds BadVAddr, Count/Compare timer, Status, Cause and EPC. It prioritises
// interrupts and WB-stage exceptions and raises a fetch redirect plus a
// younger-stage flush on a taken exception or ERET.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   wb_valid/pc/bd         WB instruction valid, PC, branch-delay-slot flag
//   wb_badvaddr            faulting data address for load/store errors
//   wb_exc                 {fetch_err,inst_rsv,overflow,syscall,break,load_err,store_err}
//   wb_eret, wb_mtc0       ERET / MTC0 in WB
//   cp0_addr, cp0_wdata    {rd,sel} register address and MTC0 write data
//   hw_int                 level-sensitive hardware interrupt requests
//   cp0_rdata              combinational MFC0 read data (0 for unimplemented)
//   exc_valid, exc_pc      redirect request and target
//   cancel                 flush younger stages (same as exc_valid)
//   status_o/cause_o/epc_o register values for display
module cp0_exc_unit #(
    parameter int unsigned N_HWINT    = 5,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wb_valid,
    input  logic [31:0]        wb_pc,
    input  logic               wb_bd,
    input  logic [31:0]        wb_badvaddr,
    input  logic [6:0]         wb_exc,
    input  logic               wb_eret,
    input  logic               wb_mtc0,
    input  logic [7:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    input  logic [N_HWINT-1:0] hw_int,
    output logic [31:0]        cp0_rdata,
    output logic               exc_valid,
    output logic [31:0]        exc_pc,
    output logic               cancel,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [31:0]   epc_q, epc_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    im_q, im_d;
    logic          exl_q, exl_d;
    logic          ie_q, ie_d;
    logic          bd_q, bd_d;
    logic          ti_q, ti_d;
    logic [4:0]    ip_hw_q, ip_hw_d;
    logic [1:0]    ip_sw_q, ip_sw_d;
    logic [4:0]    exccode_q, exccode_d;

    logic [4:0]  hw_pad;
    logic [7:0]  ip_all;
    logic        int_req;
    logic        exc_take;
    logic        eret_take;
    logic        wr_en;
    logic        count_upd;
    logic [4:0]  exc_code;
    logic        bad_upd;
    logic [31:0] bad_val;

    always_comb begin
        hw_pad = '0;
        hw_pad[N_HWINT-1:0] = hw_int;
    end

    // IP[7] is the timer interrupt, mirrored from TI.
    assign ip_all    = {ti_q, ip_hw_q, ip_sw_q};
    assign int_req   = (|(ip_all & im_q)) & ie_q & ~exl_q;
    assign exc_take  = wb_valid & (int_req | (|wb_exc));
    assign eret_take = wb_valid & wb_eret & ~exc_take;
    assign wr_en     = wb_valid & wb_mtc0 & ~exc_take;

    // Fixed priority: interrupt first, then WB exceptions in bit order.
    always_comb begin
        exc_code = 5'd0;
        bad_upd  = 1'b0;
        bad_val  = wb_badvaddr;
        if (int_req) begin
            exc_code = 5'd0;
        end else if (wb_exc[6]) begin
            exc_code = 5'd4;
            bad_upd  = 1'b1;
            bad_val  = wb_pc;
        end else if (wb_exc[5]) begin
            exc_code = 5'hA;
        end else if (wb_exc[4]) begin
            exc_code = 5'hC;
        end else if (wb_exc[3]) begin
            exc_code = 5'd8;
        end else if (wb_exc[2]) begin
            exc_code = 5'd9;
        end else if (wb_exc[1]) begin
            exc_code = 5'd4;
            bad_upd  = 1'b1;
        end else if (wb_exc[0]) begin
            exc_code = 5'd5;
            bad_upd  = 1'b1;
        end
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        presc_d    = presc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_hw_d    = hw_pad;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        count_upd  = 1'b0;

        // An explicit Count write overrides the tick and restarts the prescaler.
        if (wr_en && cp0_addr == ADDR_COUNT) begin
            count_d   = cp0_wdata;
            presc_d   = '0;
            count_upd = 1'b1;
        end else if (presc_q == PRESC_MAX) begin
            count_d   = count_q + 32'd1;
            presc_d   = '0;
            count_upd = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Compare write acknowledges the timer and beats a same-cycle match.
        if (wr_en && cp0_addr == ADDR_COMPARE) begin
            ti_d = 1'b0;
        end else if (count_upd && count_d == compare_q) begin
            ti_d = 1'b1;
        end

        if (wr_en) begin
            unique case (cp0_addr)
                ADDR_COMPARE: compare_d = cp0_wdata;
                ADDR_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                ADDR_CAUSE: ip_sw_d = cp0_wdata[9:8];
                ADDR_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end

        if (exc_take) begin
            exccode_d = exc_code;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
                bd_d  = wb_bd;
            end
            exl_d = 1'b1;
            if (bad_upd) begin
                badvaddr_d = bad_val;
            end
        end else if (eret_take) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            presc_q    <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            presc_q    <= presc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

    // BEV is hardwired to 1.
    assign status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o  = {bd_q, ti_q, 14'd0, ip_all, 1'b0, exccode_q, 2'b00};
    assign epc_o    = epc_q;

    always_comb begin
        cp0_rdata = 32'd0;
        unique case (cp0_addr)
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_q;
            ADDR_COMPARE:  cp0_rdata = compare_q;
            ADDR_STATUS:   cp0_rdata = status_o;
            ADDR_CAUSE:    cp0_rdata = cause_o;
            ADDR_EPC:      cp0_rdata = epc_q;
            default:       cp0_rdata = 32'd0;
        endcase
    end

    assign exc_valid = exc_take | eret_take;
    assign cancel    = exc_valid;
    assign exc_pc    = exc_take ? EXC_VECTOR : epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit. Expected output values are pushed to a
// scoreboard queue when stimulus is applied and popped and compared on the
// falling edge of the same cycle.
module tb_cp0_exc_unit;

    localparam logic [7:0]  A_BADV = 8'h40;
    localparam logic [7:0]  A_CNT  = 8'h48;
    localparam logic [7:0]  A_CMP  = 8'h58;
    localparam logic [7:0]  A_STAT = 8'h60;
    localparam logic [7:0]  A_CAUS = 8'h68;
    localparam logic [7:0]  A_EPC  = 8'h70;
    localparam logic [31:0] VEC    = 32'hBFC00380;

    localparam int S_EXC   = 0;
    localparam int S_PC    = 1;
    localparam int S_RD    = 2;
    localparam int S_STAT  = 3;
    localparam int S_CAUS  = 4;
    localparam int S_EPC   = 5;
    localparam int S_CANC  = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic [31:0] wb_badvaddr;
    logic [6:0]  wb_exc;
    logic        wb_eret;
    logic        wb_mtc0;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [4:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        cancel;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cp0_exc_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_bd      (wb_bd),
        .wb_badvaddr(wb_badvaddr),
        .wb_exc     (wb_exc),
        .wb_eret    (wb_eret),
        .wb_mtc0    (wb_mtc0),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .hw_int     (hw_int),
        .cp0_rdata  (cp0_rdata),
        .exc_valid  (exc_valid),
        .exc_pc     (exc_pc),
        .cancel     (cancel),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_EXC:   return {31'd0, exc_valid};
            S_PC:    return exc_pc;
            S_RD:    return cp0_rdata;
            S_STAT:  return status_o;
            S_CAUS:  return cause_o;
            S_EPC:   return epc_o;
            default: return {31'd0, cancel};
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Compare everything queued for this cycle, then move past the next edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        wb_pc = 32'd0;
        wb_bd = 1'b0;
        wb_badvaddr = 32'd0;
        wb_exc = 7'd0;
        wb_eret = 1'b0;
        wb_mtc0 = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] a, input string tag, input logic [31:0] v);
        cp0_addr = a;
        expect_out(S_RD, tag, v);
        tick();
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_mtc0 = 1'b1;
        wb_pc = 32'h400;
        cp0_addr = a;
        cp0_wdata = d;
        expect_out(S_EXC, "mtc0_noexc", 32'd0);
        tick();
        idle();
    endtask

    task automatic wb_instr(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                            input logic [31:0] badv, input logic eret);
        wb_valid = 1'b1;
        wb_pc = pc;
        wb_bd = bd;
        wb_exc = exc;
        wb_badvaddr = badv;
        wb_eret = eret;
    endtask

    initial begin
        resetn = 1'b0;
        cp0_addr = 8'd0;
        cp0_wdata = 32'd0;
        hw_int = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // 1. reset state
        expect_out(S_EXC, "rst_exc_valid", 32'd0);
        expect_out(S_CANC, "rst_cancel", 32'd0);
        read_chk(A_STAT, "rst_status", 32'h0040_0000);
        read_chk(A_CAUS, "rst_cause", 32'd0);
        read_chk(A_CNT,  "rst_count", 32'd0);
        read_chk(A_CMP,  "rst_compare", 32'd0);
        read_chk(A_EPC,  "rst_epc", 32'd0);
        read_chk(A_BADV, "rst_badvaddr", 32'd0);
        read_chk(8'h00,  "unimpl_addr", 32'd0);
        resetn = 1'b1;

        // 2. timer interrupt
        mtc0(A_CMP, 32'd5);
        mtc0(A_STAT, 32'h8001);
        mtc0(A_CNT, 32'd0);
        repeat (9) tick();
        cp0_addr = A_CNT;
        expect_out(S_RD, "count_4", 32'd4);
        expect_out(S_CAUS, "ti_not_yet", 32'd0);
        tick();
        expect_out(S_RD, "count_5", 32'd5);
        expect_out(S_CAUS, "ti_set", 32'h4000_8000);
        expect_out(S_EXC, "no_exc_wb_invalid", 32'd0);
        tick();
        wb_instr(32'h80, 1'b0, 7'd0, 32'd0, 1'b0);
        expect_out(S_EXC, "timer_exc_valid", 32'd1);
        expect_out(S_CANC, "timer_cancel", 32'd1);
        expect_out(S_PC, "timer_exc_pc", VEC);
        tick();
        idle();
        expect_out(S_EPC, "timer_epc", 32'h80);
        expect_out(S_STAT, "timer_exl", 32'h0040_8003);
        expect_out(S_CAUS, "timer_cause", 32'h4000_8000);
        expect_out(S_EXC, "exc_deassert", 32'd0);
        tick();

        // clear TI, return from the interrupt
        mtc0(A_CMP, 32'h0001_0000);
        expect_out(S_CAUS, "ti_cleared", 32'd0);
        wb_instr(32'h84, 1'b0, 7'd0, 32'd0, 1'b1);
        expect_out(S_EXC, "eret1_valid", 32'd1);
        expect_out(S_PC, "eret1_pc", 32'h80);
        tick();
        idle();
        expect_out(S_STAT, "eret1_exl_clr", 32'h0040_8001);
        tick();

        // 3. overflow beats syscall, delay-slot EPC
        wb_instr(32'h104, 1'b1, 7'b0011000, 32'd0, 1'b0);
        expect_out(S_EXC, "ov_exc_valid", 32'd1);
        expect_out(S_PC, "ov_exc_pc", VEC);
        tick();
        idle();
        expect_out(S_CAUS, "ov_cause", 32'h8000_0030);
        expect_out(S_EPC, "ov_epc_bd", 32'h100);
        expect_out(S_STAT, "ov_exl", 32'h0040_8003);
        tick();

        // 4. store error while EXL=1: EPC/BD kept, ExcCode and BadVAddr updated
        wb_instr(32'h200, 1'b0, 7'b0000001, 32'h1003, 1'b0);
        expect_out(S_EXC, "st_exc_valid", 32'd1);
        tick();
        idle();
        expect_out(S_CAUS, "st_cause", 32'h8000_0014);
        expect_out(S_EPC, "st_epc_kept", 32'h100);
        read_chk(A_BADV, "st_badvaddr", 32'h1003);
        // fetch_err beats load_err and captures the PC
        wb_instr(32'h2000, 1'b0, 7'b1000010, 32'h3000, 1'b0);
        expect_out(S_EXC, "fe_exc_valid", 32'd1);
        tick();
        idle();
        expect_out(S_CAUS, "fe_cause", 32'h8000_0010);
        read_chk(A_BADV, "fe_badvaddr", 32'h2000);
        wb_instr(32'h2004, 1'b0, 7'd0, 32'd0, 1'b1);
        expect_out(S_EXC, "eret2_valid", 32'd1);
        expect_out(S_PC, "eret2_pc", 32'h100);
        tick();
        idle();
        expect_out(S_STAT, "eret2_exl_clr", 32'h0040_8001);
        tick();

        // 5. hardware interrupt masked by EXL, then taken once EXL clears
        mtc0(A_STAT, 32'h1003);
        hw_int = 5'b00100;
        tick();
        wb_instr(32'h200, 1'b0, 7'd0, 32'd0, 1'b0);
        expect_out(S_EXC, "hw_masked_exl", 32'd0);
        expect_out(S_CAUS, "hw_ip4", 32'h8000_1010);
        tick();
        idle();
        mtc0(A_STAT, 32'h1001);
        wb_instr(32'h300, 1'b0, 7'd0, 32'd0, 1'b0);
        expect_out(S_EXC, "hw_taken", 32'd1);
        expect_out(S_PC, "hw_exc_pc", VEC);
        tick();
        idle();
        expect_out(S_EPC, "hw_epc", 32'h300);
        expect_out(S_CAUS, "hw_cause", 32'h0000_1000);
        expect_out(S_STAT, "hw_status", 32'h0040_1003);
        tick();
        hw_int = 5'd0;
        mtc0(A_STAT, 32'd0);
        expect_out(S_STAT, "status_cleared", 32'h0040_0000);
        tick();

        // 6. Count wrap, TI on match, Compare write on match cycle wins
        expect_out(S_RD, "mfc0_prewrite", 32'h0001_0000);
        mtc0(A_CMP, 32'd0);
        mtc0(A_CNT, 32'hFFFF_FFFF);
        read_chk(A_CNT, "count_ffff", 32'hFFFF_FFFF);
        tick();
        cp0_addr = A_CNT;
        expect_out(S_RD, "count_wrap", 32'd0);
        expect_out(S_CAUS, "wrap_ti_set", 32'h4000_8000);
        tick();
        mtc0(A_CMP, 32'd0);
        mtc0(A_CNT, 32'hFFFF_FFFF);
        tick();
        mtc0(A_CMP, 32'd0);
        cp0_addr = A_CNT;
        expect_out(S_RD, "count_wrap2", 32'd0);
        expect_out(S_CAUS, "cmp_write_wins", 32'd0);
        tick();
        mtc0(A_CAUS, 32'hFFFF_FFFF);
        expect_out(S_CAUS, "cause_sw_ip_only", 32'h0000_0300);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
